// File: rtl/cache_line_word_sel.sv
// Critical-word-first word selector for one cache line.
// A request latches a whole line and a start offset. The block then sends
// either that single word or all WORDS words, wrapping modulo WORDS.
//
// Handshake rules (both sides):
//   A transfer happens at a rising clk edge when valid && ready are both high.
//   A producer holding valid may not change its payload until that edge.
//   Valid never depends combinationally on ready.
//   in_ready is high only in IDLE; out_valid is high only in SEND.
module cache_line_word_sel #(
  parameter int WORD_W = 32,
  parameter int WORDS  = 4,
  localparam int OFF_W = $clog2(WORDS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORDS*WORD_W-1:0] in_line,
  input  logic [OFF_W-1:0]        in_offset,
  input  logic                    in_burst,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W-1:0]       out_data,
  output logic [OFF_W-1:0]        out_index,
  output logic                    out_last,
  output logic                    dbg_state
);

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  state_t                        r_state;
  logic [WORDS-1:0][WORD_W-1:0]  r_line;
  logic [OFF_W-1:0]              r_ptr;
  logic [OFF_W-1:0]              r_rem;

  logic w_accept;
  logic w_beat;
  logic w_last;

  assign in_ready  = (r_state == S_IDLE) && !rst;
  assign w_accept  = in_valid && in_ready;
  assign out_valid = (r_state == S_SEND);
  assign w_last    = (r_rem == '0);
  assign out_last  = out_valid && w_last;
  assign w_beat    = out_valid && out_ready;

  // In IDLE these show whatever the registers hold.
  // Reset clears the registers, so both read 0 during reset.
  assign out_data  = r_line[r_ptr];
  assign out_index = r_ptr;
  assign dbg_state = r_state;

  // Controller: latch a request in IDLE, then walk the line one beat at a time.
  // The pointer wraps for free because WORDS is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_line  <= '0;
      r_ptr   <= '0;
      r_rem   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_line  <= in_line;
            r_ptr   <= in_offset;
            r_rem   <= in_burst ? OFF_W'(WORDS - 1) : '0;
            r_state <= S_SEND;
          end
        end
        S_SEND: begin
          if (w_beat) begin
            if (w_last) begin
              r_state <= S_IDLE;
            end else begin
              r_ptr <= r_ptr + OFF_W'(1);
              r_rem <= r_rem - OFF_W'(1);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_line_word_sel.sv
// Bench for cache_line_word_sel.
// Contents: directed vector table, hand-written corner sequences,
// a WORDS=8 wrap case, and a randomized run against a beat-list model.
module tb_cache_line_word_sel;

  localparam int W  = 32;
  localparam int N  = 4;
  localparam int N8 = 8;
  localparam int BW = W + 2 + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // main DUT (WORDS = 4)
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N*W-1:0] in_line = '0;
  logic [1:0]     in_offset = '0;
  logic           in_burst = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_data;
  logic [1:0]     out_index;
  logic           out_last;
  logic           dbg_state;

  cache_line_word_sel #(.WORD_W(W), .WORDS(N)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_line(in_line),
    .in_offset(in_offset), .in_burst(in_burst),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .dbg_state(dbg_state)
  );

  // second DUT (WORDS = 8)
  logic            b_in_valid = 1'b0;
  logic            b_in_ready;
  logic [N8*W-1:0] b_in_line = '0;
  logic [2:0]      b_in_offset = '0;
  logic            b_in_burst = 1'b0;
  logic            b_out_valid;
  logic            b_out_ready = 1'b0;
  logic [W-1:0]    b_out_data;
  logic [2:0]      b_out_index;
  logic            b_out_last;
  logic            b_dbg_state;

  cache_line_word_sel #(.WORD_W(W), .WORDS(N8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_line(b_in_line),
    .in_offset(b_in_offset), .in_burst(b_in_burst),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_index(b_out_index), .out_last(b_out_last), .dbg_state(b_dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic       burst;
    logic [1:0] off;
    int         stall;
    int         n;
    int         d[4];
    int         ix[4];
  } vec_t;

  logic [N*W-1:0] line_a;
  logic [N*W-1:0] line_b;

  // Send one request from the table, then check every beat in order.
  task automatic run_vec(input vec_t v, input int id);
    @(negedge clk);
    in_line = line_a; in_offset = v.off; in_burst = v.burst;
    in_valid = 1'b1; out_ready = 1'b1;
    #1 check($sformatf("v%0d_acc_ready", id), in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int b = 0; b < v.n; b++) begin
      if (b == 0) begin
        for (int s = 0; s < v.stall; s++) begin
          out_ready = 1'b0;
          #1;
          check($sformatf("v%0d_stall_valid", id), out_valid, 1);
          check($sformatf("v%0d_stall_data", id), out_data, v.d[0]);
          check($sformatf("v%0d_stall_idx", id), out_index, v.ix[0]);
          check($sformatf("v%0d_stall_last", id), out_last, (v.n == 1));
          @(negedge clk);
        end
      end
      out_ready = 1'b1;
      #1;
      check($sformatf("v%0d_b%0d_valid", id, b), out_valid, 1);
      check($sformatf("v%0d_b%0d_data", id, b), out_data, v.d[b]);
      check($sformatf("v%0d_b%0d_idx", id, b), out_index, v.ix[b]);
      check($sformatf("v%0d_b%0d_last", id, b), out_last, (b == v.n - 1));
      @(negedge clk);
    end
    #1;
    check($sformatf("v%0d_done_valid", id), out_valid, 0);
    check($sformatf("v%0d_done_ready", id), in_ready, 1);
  endtask

  // ---------------- random phase: scoreboard ----------------
  // Each accepted request becomes its list of beats {data, index, last}.
  // The list is built directly from the line and the wrap order.
  logic [BW-1:0] exp_q[$];

  task automatic rand_step(input bit allow_req);
    logic [BW-1:0] got;
    int n;
    int idx;
    @(negedge clk);
    out_ready = ($urandom_range(0, 3) != 0);
    in_valid  = allow_req ? 1'($urandom_range(0, 1)) : 1'b0;
    for (int w = 0; w < N; w++) in_line[w*W +: W] = $urandom();
    in_offset = 2'($urandom_range(0, N - 1));
    in_burst  = 1'($urandom_range(0, 1));
    if (!allow_req) out_ready = 1'b1;
    #1;
    check("rnd_in_ready", in_ready, (exp_q.size() == 0));
    check("rnd_out_valid", out_valid, (exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      got = {out_data, out_index, out_last};
      check("rnd_beat", got, exp_q[0]);
      if (out_ready) void'(exp_q.pop_front());
    end else if (in_valid) begin
      n = in_burst ? N : 1;
      for (int k = 0; k < n; k++) begin
        idx = (int'(in_offset) + k) % N;
        exp_q.push_back({in_line[idx*W +: W], 2'(idx), (k == n - 1)});
      end
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vec_t vt[4];
    int beats;
    for (int i = 0; i < N; i++) begin
      line_a[i*W +: W] = 32'(i * 100);
      line_b[i*W +: W] = 32'hB000_0000 + 32'(i);
    end
    vt[0] = '{burst:1'b0, off:2'd2, stall:0, n:1, d:'{200, 0, 0, 0},   ix:'{2, 0, 0, 0}};
    vt[1] = '{burst:1'b1, off:2'd1, stall:0, n:4, d:'{100, 200, 300, 0}, ix:'{1, 2, 3, 0}};
    vt[2] = '{burst:1'b1, off:2'd3, stall:2, n:4, d:'{300, 0, 100, 200}, ix:'{3, 0, 1, 2}};
    vt[3] = '{burst:1'b0, off:2'd0, stall:1, n:1, d:'{0, 0, 0, 0},     ix:'{0, 0, 0, 0}};

    // reset state, observed before any clock edge
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_index", out_index, 0);
    check("rst_out_last", out_last, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check("rel_in_ready", in_ready, 1);

    for (int i = 0; i < 4; i++) run_vec(vt[i], i);

    // A new request during SEND is ignored, then accepted once back in IDLE.
    @(negedge clk);
    in_line = line_a; in_offset = 2'd0; in_burst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_line = line_b;
    for (int b = 0; b < N; b++) begin
      #1;
      check("ign_in_ready", in_ready, 0);
      check("ign_data", out_data, b * 100);
      check("ign_idx", out_index, b);
      @(negedge clk);
    end
    in_offset = 2'd1; in_burst = 1'b0;
    #1 check("ign_idle_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("ign_new_valid", out_valid, 1);
    check("ign_new_data", out_data, line_b[1*W +: W]);
    check("ign_new_last", out_last, 1);
    @(negedge clk);
    #1 check("ign_new_done", out_valid, 0);

    // Reset in the middle of a burst aborts it at once.
    @(negedge clk);
    in_line = line_a; in_offset = 2'd0; in_burst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      #1 check("ab_data", out_data, b * 100);
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    check("ab_out_valid", out_valid, 0);
    check("ab_in_ready", in_ready, 0);
    check("ab_out_data", out_data, 0);
    check("ab_out_index", out_index, 0);
    check("ab_out_last", out_last, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ab_rel_ready", in_ready, 1);
    check("ab_rel_valid", out_valid, 0);
    in_offset = 2'd0; in_burst = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("ab_single_valid", out_valid, 1);
    check("ab_single_data", out_data, 0);
    check("ab_single_last", out_last, 1);
    @(negedge clk);
    #1 check("ab_single_done", out_valid, 0);

    // WORDS = 8, burst starting at the top index wraps to 0.
    for (int i = 0; i < N8; i++) b_in_line[i*W +: W] = 32'(1000 + i);
    @(negedge clk);
    b_in_offset = 3'd7; b_in_burst = 1'b1; b_in_valid = 1'b1; b_out_ready = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    beats = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (b_out_valid) begin
        check("w8_idx", b_out_index, (7 + beats) % N8);
        check("w8_data", b_out_data, 1000 + ((7 + beats) % N8));
        check("w8_last", b_out_last, (beats == N8 - 1));
        beats++;
      end
      @(negedge clk);
    end
    check("w8_beats", beats, N8);

    // Randomized traffic against the beat-list model.
    exp_q.delete();
    for (int c = 0; c < 3000; c++) rand_step(1'b1);
    for (int c = 0; c < 8; c++) rand_step(1'b0);
    check("rnd_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the bench always ends on its own.
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached with %0d errors", n_errors);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cache_line_word_sel.md
CACHE_LINE_WORD_SEL -- requirements
Module: cache_line_word_sel

Interface
REQ-001 SHALL have parameter WORD_W, default 32: bits per data word.
REQ-002 SHALL have parameter WORDS, default 4: words per cache line; power of two, >= 2.
REQ-003 SHALL have derived parameter OFF_W = clog2(WORDS): word-offset width.
REQ-004 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1: a request is presented.
REQ-007 SHALL have port in_ready, output, 1: block can accept a request.
REQ-008 SHALL have port in_line, input, WORDS*WORD_W: line data; word i at bits [i*WORD_W +: WORD_W].
REQ-009 SHALL have port in_offset, input, OFF_W: first (critical) word index.
REQ-010 SHALL have port in_burst, input, 1: 0 selects a single-word transfer; 1 streams the whole line.
REQ-011 SHALL have port out_valid, output, 1: out_data is valid.
REQ-012 SHALL have port out_ready, input, 1: consumer accepts the current word.
REQ-013 SHALL have port out_data, output, WORD_W: selected word.
REQ-014 SHALL have port out_index, output, OFF_W: index of the word on out_data.
REQ-015 SHALL have port out_last, output, 1: current beat is the final beat of the transfer.

Function
REQ-016 SHALL implement a two-state FSM: IDLE and SEND.
REQ-017 SHALL drive in_ready = 1 only in IDLE while rst is low, and 0 in SEND.
REQ-018 SHALL accept a request when in_valid && in_ready at a clock edge.
REQ-019 On accept, SHALL latch in_line into the line register, set ptr = in_offset, set remaining = in_burst ? WORDS-1 : 0, and enter SEND.
REQ-020 SHALL drive out_valid = 1 from the first cycle after acceptance; latency is one cycle.
REQ-021 In SEND, SHALL drive out_data = line[ptr], out_index = ptr and out_last = (remaining == 0).
REQ-022 On a beat (out_valid && out_ready) with out_last = 1, SHALL return to IDLE; out_valid falls in the next cycle.
REQ-023 On a beat with out_last = 0, SHALL set ptr = (ptr + 1) mod WORDS and decrement remaining, giving critical-word-first wrap order.
REQ-024 On a stall (out_valid && !out_ready), SHALL hold out_data, out_index and out_last stable, with no skipped or duplicated words.
REQ-025 SHALL ignore in_valid and in_line changes during SEND; the transfer uses only the latched line.
REQ-026 SHALL leave at least one IDLE cycle between consecutive transfers.
REQ-027 In IDLE, SHALL drive out_valid = 0, out_last = 0, and out_data / out_index from the register contents (don't-care for consumers).
REQ-028 SHALL complete a burst in exactly WORDS beats; each index 0..WORDS-1 appears exactly once.

Reset
REQ-029 While rst = 1, SHALL immediately, without waiting for clk, force state = IDLE, out_valid = 0, out_last = 0, in_ready = 0, ptr = 0, remaining = 0, line register = 0, out_data = 0 and out_index = 0.
REQ-030 Reset asserted mid-transfer SHALL abort the transfer with no further beats.
REQ-031 SHALL raise in_ready in the first cycle after rst deasserts.

Verification
(Defaults WORD_W = 32, WORDS = 4; line words w0 = 0, w1 = 100, w2 = 200, w3 = 300.)
REQ-032 Single, offset 2, out_ready = 1 -> one beat 200 / index 2 / last = 1, one cycle after accept; in_ready = 1 the cycle after the beat.
REQ-033 Burst, offset 1, out_ready = 1 -> beats 100, 200, 300, 0 on indices 1, 2, 3, 0 in consecutive cycles; last = 1 only on the 4th beat.
REQ-034 Burst, offset 3, out_ready low for 2 cycles after the first out_valid -> data 300 / index 3 held for 3 cycles, then 0, 100, 200; no loss or repeat.
REQ-035 New in_valid with a different line during SEND -> in_ready = 0, request ignored, current burst data unchanged; request accepted after return to IDLE.
REQ-036 rst pulsed after 2 burst beats -> out_valid = 0 in the same cycle, in_ready = 1 after release; next single request at offset 0 returns 0.
REQ-037 WORDS = 8, burst at offset 7 -> indices 7, 0, 1, ..., 6 in exactly 8 beats, last on index 6.
